fifo_burst_drain: RTL and testbench

// - Read-side controller directly downstream of synch_fifo; sole driver of its rd_en.
// - Watches existed_entries/empty, drains the FIFO in bursts of BURST_LEN entries toward a sink.
// - Flushes a partial burst after TIMEOUT cycles of waiting, so a few entries never stall indefinitely.
// - Per read, presents the FIFO slot address (rd_ptr) to the sink with a valid strobe.

---
 rtl/fifo_burst_drain_pkg.sv | 18 +
 rtl/fifo_burst_drain_timer.sv | 37 +++
 rtl/fifo_burst_drain.sv | 130 +++++++++++++
 tb/tb_fifo_burst_drain.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_drain_pkg.sv
// Shared types and defaults for the FIFO burst-drain read controller.
package fifo_burst_drain_pkg;

  localparam int unsigned DefPtrW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StBurst = 2'd2,
    StGap   = 2'd3
  } drain_state_e;

  // Counter wide enough to hold values up to and including the timeout.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_drain_timer.sv
// Clear/increment wait timer with a terminal-count flag at Timeout-1.
module drain_timer
  import fifo_burst_drain_pkg::*;
#(
  parameter int unsigned Timeout = 8,
  parameter int unsigned Width   = timer_width(Timeout)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [Width-1:0] count_q, count_d;

  assign tc_o = (count_q == Width'(Timeout - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !tc_o) begin
      // Holds at terminal count; the controller leaves WAIT on that cycle anyway.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// Read-side controller for synch_fifo: drains entries in fixed-size bursts toward a sink,
// flushing a partial burst once the wait timer expires.
module fifo_burst_drain
  import fifo_burst_drain_pkg::*;
#(
  parameter int unsigned PTR_W     = DefPtrW,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PTR_W-1:0] existed_entries,
  input  logic             empty,
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic             sink_ready,
  output logic             rd_en,
  output logic             rd_valid,
  output logic [PTR_W-1:0] rd_addr,
  output logic             burst_active,
  output logic [PTR_W-1:0] burst_len_out,
  output logic             burst_done
);

  localparam logic [PTR_W-1:0] BurstLenW = PTR_W'(BURST_LEN);

  drain_state_e     state_q, state_d;
  logic [PTR_W-1:0] remaining_q, remaining_d;
  logic [PTR_W-1:0] burst_len_q, burst_len_d;
  logic             rd_valid_q;
  logic [PTR_W-1:0] rd_addr_q;
  logic             burst_done_q;

  logic full_avail;
  logic last_read;
  logic timer_clear;
  logic timer_inc;
  logic timer_tc;

  assign full_avail = (existed_entries >= BurstLenW);
  // remaining<=1 also covers a degenerate zero-length flush, so the counter never wraps.
  assign last_read  = rd_en && (remaining_q <= PTR_W'(1));

  drain_timer #(
    .Timeout(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(timer_clear),
    .inc_i  (timer_inc),
    .tc_o   (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    burst_len_d = burst_len_q;
    rd_en       = 1'b0;
    timer_clear = 1'b1;
    timer_inc   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && full_avail) begin
          state_d     = StBurst;
          remaining_d = BurstLenW;
          burst_len_d = BurstLenW;
        end else if (enable && !empty) begin
          state_d = StWait;
        end
      end
      StWait: begin
        timer_clear = 1'b0;
        timer_inc   = 1'b1;
        if (full_avail) begin
          state_d     = StBurst;
          remaining_d = BurstLenW;
          burst_len_d = BurstLenW;
        end else if (empty) begin
          state_d = StIdle;
        end else if (timer_tc) begin
          state_d     = StBurst;
          remaining_d = existed_entries;
          burst_len_d = existed_entries;
        end
      end
      StBurst: begin
        rd_en = sink_ready && !empty;
        if (last_read) begin
          state_d = StGap;
        end else if (rd_en) begin
          remaining_d = remaining_q - 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      burst_len_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      burst_len_q  <= burst_len_d;
      rd_valid_q   <= rd_en;
      burst_done_q <= last_read;
      if (rd_en) begin
        rd_addr_q <= rd_ptr;
      end
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_addr       = rd_addr_q;
  assign burst_active  = (state_q == StBurst);
  assign burst_len_out = burst_len_q;
  assign burst_done    = burst_done_q;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: behavioural FIFO plus burst-rule model, directed and random phases.
module tb_fifo_burst_drain;

  localparam int PtrW   = 4;
  localparam int BL     = 4;
  localparam int TO     = 8;
  localparam int MaxOcc = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [PtrW-1:0] existed_entries;
  logic            empty;
  logic [PtrW-1:0] rd_ptr;
  logic            sink_ready;
  logic            rd_en;
  logic            rd_valid;
  logic [PtrW-1:0] rd_addr;
  logic            burst_active;
  logic [PtrW-1:0] burst_len_out;
  logic            burst_done;

  fifo_burst_drain #(
    .PTR_W    (PtrW),
    .BURST_LEN(BL),
    .TIMEOUT  (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .existed_entries(existed_entries),
    .empty          (empty),
    .rd_ptr         (rd_ptr),
    .sink_ready     (sink_ready),
    .rd_en          (rd_en),
    .rd_valid       (rd_valid),
    .rd_addr        (rd_addr),
    .burst_active   (burst_active),
    .burst_len_out  (burst_len_out),
    .burst_done     (burst_done)
  );

  always #100 clk = ~clk;

  // FIFO occupancy/read-pointer stand-in for synch_fifo.
  int            f_cnt = 0;
  logic [PtrW-1:0] f_rd = '0;

  // Reference model: reads left in the burst, gap flag, wait cycles so far (-1 = not waiting).
  int            m_left = 0;
  bit            m_gap  = 1'b0;
  int            m_wait = -1;
  int            m_len  = 0;
  logic          m_valid = 1'b0;
  logic [PtrW-1:0] m_addr = '0;
  logic          m_done = 1'b0;

  int n_pass   = 0;
  int n_checks = 0;
  int step_idx = 0;
  int done_cnt = 0;
  int min_occ  = 0;
  int rden_idx[$];
  logic [PtrW-1:0] addr_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (step %0d)", name, act, exp, step_idx);
  endtask

  task automatic drive_fifo_outs();
    existed_entries = PtrW'(f_cnt);
    empty           = (f_cnt == 0);
    rd_ptr          = f_rd;
  endtask

  task automatic start_burst(input int n);
    m_left = n;
    m_len  = n;
    m_wait = -1;
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit w, input bit chk);
    bit exp_en;
    bit dut_en;
    int cnt;
    logic [PtrW-1:0] ptr;
    @(negedge clk);
    rst = r; enable = e; sink_ready = s;
    drive_fifo_outs();
    #1;
    exp_en = (m_left > 0) && s && (f_cnt > 0);
    if (chk) begin
      check("rd_en", rd_en, exp_en);
      check("rd_valid", rd_valid, m_valid);
      check("rd_addr", rd_addr, m_addr);
      check("burst_active", burst_active, m_left > 0);
      check("burst_len_out", burst_len_out, m_len);
      check("burst_done", burst_done, m_done);
    end
    if (rd_en === 1'b1) rden_idx.push_back(step_idx);
    if (rd_valid === 1'b1) addr_q.push_back(rd_addr);
    if (burst_done === 1'b1) done_cnt++;
    if (f_cnt < min_occ) min_occ = f_cnt;
    dut_en = (rd_en === 1'b1);
    cnt = f_cnt;
    ptr = f_rd;
    @(posedge clk);
    #1;
    if (dut_en && cnt > 0) begin
      f_rd  = f_rd + 1'b1;
      f_cnt = f_cnt - 1;
    end
    if (w && cnt < MaxOcc) f_cnt = f_cnt + 1;
    if (r) begin
      m_left = 0; m_gap = 1'b0; m_wait = -1; m_len = 0;
      m_valid = 1'b0; m_addr = '0; m_done = 1'b0;
    end else begin
      m_valid = exp_en;
      if (exp_en) m_addr = ptr;
      m_done = exp_en && (m_left == 1);
      if (m_left > 0) begin
        if (exp_en) begin
          m_left--;
          if (m_left == 0) m_gap = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (m_wait >= 0) begin
        if (cnt >= BL) start_burst(BL);
        else if (cnt == 0) m_wait = -1;
        else if (m_wait == TO - 1) start_burst(cnt);
        else m_wait++;
      end else if (e && cnt >= BL) begin
        start_burst(BL);
      end else if (e && cnt > 0) begin
        m_wait = 0;
      end
    end
    drive_fifo_outs();
    step_idx++;
  endtask

  task automatic clear_log();
    rden_idx.delete();
    addr_q.delete();
    done_cnt = 0;
    step_idx = 0;
  endtask

  initial begin
    int n_gap;
    rst = 1'b1; enable = 1'b0; sink_ready = 1'b0;
    drive_fifo_outs();

    // Reset with arbitrary control inputs.
    for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    check("reset_rd_en", rd_en, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_burst_active", burst_active, 0);
    check("reset_burst_len_out", burst_len_out, 0);

    // Full burst from 6 entries, then the leftover 2 flush after the wait.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    clear_log();
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("full_reads", rden_idx.size(), 6);
    check("full_first_rd", rden_idx[0], 1);
    check("full_fourth_rd", rden_idx[3], 4);
    check("full_flush_rd", rden_idx[4], 15);
    for (int i = 0; i < 6; i++) check("full_addr", addr_q[i], i);
    check("full_done_cnt", done_cnt, 2);
    check("full_len_after_flush", burst_len_out, 2);

    // Flush of a 2-entry partial burst.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    clear_log();
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("flush_reads", rden_idx.size(), 2);
    check("flush_first_rd", rden_idx[0], 9);
    check("flush_len", burst_len_out, 2);
    check("flush_fifo_empty", f_cnt, 0);
    check("flush_done_cnt", done_cnt, 1);

    // Sink stall: sink_ready toggles so the first burst cycle sees ready.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    clear_log();
    for (int i = 0; i < 26; i++) step(1'b0, 1'b1, 1'(i % 2), 1'b0, 1'b1);
    check("stall_reads", rden_idx.size(), 8);
    check("stall_first_rd", rden_idx[0], 1);
    check("stall_fourth_rd", rden_idx[3], 7);
    check("stall_second_burst", rden_idx[4], 11);
    check("stall_done_cnt", done_cnt, 2);

    // Reset in the cycle of the second read of a 4-burst.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    clear_log();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("mid_reset_reads", rden_idx.size(), 2);
    check("mid_reset_done_cnt", done_cnt, 0);
    check("mid_reset_active", burst_active, 0);
    check("mid_reset_left", f_cnt, 2);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("mid_reset_drained", f_cnt, 0);

    // Writes held high during bursts: back-to-back bursts separated by GAP+IDLE.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    clear_log();
    min_occ = f_cnt;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_gap = 0;
    for (int i = 1; i < rden_idx.size(); i++) begin
      if (rden_idx[i] - rden_idx[i-1] != 1) begin
        n_gap++;
        check("simul_gap", rden_idx[i] - rden_idx[i-1], 3);
      end
    end
    check("simul_gap_count", int'(n_gap >= 4), 1);
    check("simul_min_occ", int'(min_occ >= BL), 1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
